// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state, configuration and sizing helpers for conv2d_stream
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      DRAIN,
      OUT,
      DONE
   } state_e;

   typedef struct packed {
      logic [7:0] n;
      logic [7:0] k;
      logic [7:0] s;
      logic [3:0] p;
      logic [7:0] o;
   } cfg_t;

   // Output side length floor((N + 2P - K) / S) + 1; zero for shapes that cannot fit.
   function automatic logic [7:0] out_size(input logic [7:0] n, input logic [7:0] k,
                                           input logic [7:0] s, input logic [3:0] p);
      logic [8:0] span;
      logic [8:0] q;
      span = {1'b0, n} + {4'b0, p, 1'b0};
      if (s == 8'd0 || {1'b0, k} > span) begin
         return 8'd0;
      end
      q = (span - {1'b0, k}) / {1'b0, s};
      return 8'(q + 9'd1);
   endfunction

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - multiply, sign/zero extend and clear-or-accumulate stage
module conv_mac #(
   parameter int DW     = 8,
   parameter int ACC_W  = 20,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             zero,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   output logic [ACC_W-1:0] acc
);

   logic [2*DW-1:0]  prod_u;
   logic [2*DW-1:0]  prod_s;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_q;

   always_comb begin
      prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      // Low 2*DW bits of the product of the sign-extended operands equal the signed product.
      prod_s = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
      if (SIGNED != 0) begin
         prod_ext = {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
      end else begin
         prod_ext = {{(ACC_W-2*DW){1'b0}}, prod_u};
      end
      if (zero) begin
         prod_ext = '0;
      end
      acc_d = acc_q;
      if (en) begin
         acc_d = (clr ? '0 : acc_q) + prod_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - 2-D convolution engine: FSM, tap/pixel counters, address generation
module conv2d_stream
   import conv_pkg::*;
#(
   parameter int DW      = 8,
   parameter int AW      = 20,
   parameter int ACC_W   = 20,
   parameter int MAX_IMG = 64,
   parameter int MAX_K   = 7,
   parameter int SIGNED  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       img_size,
   input  logic [7:0]       k_size,
   input  logic [7:0]       stride,
   input  logic [3:0]       pad,
   output logic             img_rd,
   output logic [AW-1:0]    img_addr,
   input  logic [DW-1:0]    img_data,
   output logic [AW-1:0]    k_addr,
   input  logic [DW-1:0]    k_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [7:0]       out_row,
   output logic [7:0]       out_col,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   localparam logic [7:0] MAX_IMG_B = 8'(MAX_IMG);
   localparam logic [7:0] MAX_K_B   = 8'(MAX_K);

   state_e state_q, state_d;
   cfg_t   cfg_q, cfg_d, cfg_new;
   logic [7:0] kr_q, kr_d, kc_q, kc_d, orow_q, orow_d, ocol_q, ocol_d;
   logic cfg_ok, cfg_err_q, cfg_err_d;
   logic issue_q, issue_d, first_q, first_d, img_rd_q, img_rd_d;
   logic [AW-1:0] img_addr_q, img_addr_d, k_addr_q, k_addr_d;
   logic mac_en_q, mac_en_d, mac_clr_q, mac_clr_d, mac_inb_q, mac_inb_d;
   logic [8:0]  span;
   logic [15:0] base_r, base_c, lin_img, lin_k;
   logic signed [17:0] row_c, col_c;
   logic in_b;
   logic [ACC_W-1:0] acc;

   always_comb begin
      cfg_new.n = img_size;
      cfg_new.k = k_size;
      cfg_new.s = stride;
      cfg_new.p = pad;
      cfg_new.o = out_size(img_size, k_size, stride, pad);
      span = {1'b0, img_size} + {4'b0, pad, 1'b0};
      cfg_ok = (k_size != 8'd0) && (stride != 8'd0) && ({1'b0, k_size} <= span) &&
               (img_size <= MAX_IMG_B) && (k_size <= MAX_K_B);

      state_d   = state_q;
      cfg_d     = cfg_q;
      kr_d      = kr_q;
      kc_d      = kc_q;
      orow_d    = orow_q;
      ocol_d    = ocol_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  cfg_d   = cfg_new;
                  state_d = MAC;
                  kr_d    = 8'd0;
                  kc_d    = 8'd0;
                  orow_d  = 8'd0;
                  ocol_d  = 8'd0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         MAC: begin
            if (kc_q == cfg_q.k - 8'd1) begin
               kc_d = 8'd0;
               if (kr_q == cfg_q.k - 8'd1) begin
                  state_d = DRAIN;
               end else begin
                  kr_d = kr_q + 8'd1;
               end
            end else begin
               kc_d = kc_q + 8'd1;
            end
         end
         DRAIN: state_d = OUT;
         OUT: begin
            if (out_ready) begin
               kr_d    = 8'd0;
               kc_d    = 8'd0;
               state_d = MAC;
               if (ocol_q == cfg_q.o - 8'd1) begin
                  ocol_d = 8'd0;
                  if (orow_q == cfg_q.o - 8'd1) begin
                     state_d = DONE;
                  end else begin
                     orow_d = orow_q + 8'd1;
                  end
               end else begin
                  ocol_d = ocol_q + 8'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Address of the tap presented next cycle, computed from the next-state counters.
      issue_d = (state_d == MAC);
      first_d = issue_d && (kr_d == 8'd0) && (kc_d == 8'd0);
      base_r  = {8'b0, orow_d} * {8'b0, cfg_d.s};
      base_c  = {8'b0, ocol_d} * {8'b0, cfg_d.s};
      row_c   = $signed({2'b0, base_r}) + $signed({10'b0, kr_d}) - $signed({14'b0, cfg_d.p});
      col_c   = $signed({2'b0, base_c}) + $signed({10'b0, kc_d}) - $signed({14'b0, cfg_d.p});
      in_b    = (row_c >= 18'sd0) && (row_c < $signed({10'b0, cfg_d.n})) &&
                (col_c >= 18'sd0) && (col_c < $signed({10'b0, cfg_d.n}));
      lin_img = {8'b0, row_c[7:0]} * {8'b0, cfg_d.n} + {8'b0, col_c[7:0]};
      lin_k   = {8'b0, kr_d} * {8'b0, cfg_d.k} + {8'b0, kc_d};
      img_rd_d   = issue_d && in_b;
      img_addr_d = img_rd_d ? AW'(lin_img) : '0;
      k_addr_d   = issue_d ? AW'(lin_k) : '0;

      // Memory data for a tap lands one cycle after issue, so its controls trail by one.
      mac_en_d  = issue_q;
      mac_clr_d = first_q;
      mac_inb_d = img_rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cfg_q      <= '0;
         kr_q       <= '0;
         kc_q       <= '0;
         orow_q     <= '0;
         ocol_q     <= '0;
         cfg_err_q  <= 1'b0;
         issue_q    <= 1'b0;
         first_q    <= 1'b0;
         img_rd_q   <= 1'b0;
         img_addr_q <= '0;
         k_addr_q   <= '0;
         mac_en_q   <= 1'b0;
         mac_clr_q  <= 1'b0;
         mac_inb_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         kr_q       <= kr_d;
         kc_q       <= kc_d;
         orow_q     <= orow_d;
         ocol_q     <= ocol_d;
         cfg_err_q  <= cfg_err_d;
         issue_q    <= issue_d;
         first_q    <= first_d;
         img_rd_q   <= img_rd_d;
         img_addr_q <= img_addr_d;
         k_addr_q   <= k_addr_d;
         mac_en_q   <= mac_en_d;
         mac_clr_q  <= mac_clr_d;
         mac_inb_q  <= mac_inb_d;
      end
   end

   conv_mac #(
      .DW     (DW),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
   ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .en   (mac_en_q),
      .clr  (mac_clr_q),
      .zero (!mac_inb_q),
      .a    (img_data),
      .b    (k_data),
      .acc  (acc)
   );

   assign img_rd    = img_rd_q;
   assign img_addr  = img_addr_q;
   assign k_addr    = k_addr_q;
   assign out_valid = (state_q == OUT);
   assign out_data  = acc;
   assign out_row   = orow_q;
   assign out_col   = ocol_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign cfg_err   = cfg_err_q;

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Parametrised 2-D convolution engine: computes one output pixel at a time over a square row-major image using a square kernel, with configurable stride, zero padding and signed/unsigned arithmetic. It fetches image and kernel samples from external synchronous memories and delivers results over a valid/ready stream with row/column tags. It is the next-generation convolution datapath, replacing fixed-geometry address counting with a checked configuration, backpressure and completion signalling.

## Interface
- DW, 8, sample width of image and kernel data
- AW, 20, image/kernel address width
- ACC_W, 20, accumulator and output width
- MAX_IMG, 64, largest supported img_size
- MAX_K, 7, largest supported k_size
- SIGNED, 0, 1 = operands and products two's-complement
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- img_size  in  8  image side length N
- k_size  in  8  kernel side length K
- stride  in  8  step S between output positions
- pad  in  4  zero-padding width P on every edge
- img_rd  out  1  image read strobe
- img_addr  out  AW  image address, row*N+col, 0-based
- img_data  in  DW  image sample, valid the cycle after img_rd
- k_addr  out  AW  kernel address, kr*K+kc, 0-based
- k_data  in  DW  kernel sample, valid the cycle after k_addr issued
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  convolution sum
- out_row, out_col  out  8 each  output coordinates
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after last result accepted
- cfg_err  out  1  one-cycle pulse on rejected configuration

## Operation
- Output side O = floor((N + 2P - K)/S) + 1; outputs produced raster order (row-major), O*O results per job.
- Config latched in the start cycle. Rejected (cfg_err pulse, no reads, no outputs, stay IDLE) if K=0, S=0, K > N+2P, N > MAX_IMG, or K > MAX_K.
- FSM: IDLE -> MAC on valid start; MAC issues K*K taps, kernel row-major, one per cycle; MAC -> DRAIN after last tap; DRAIN accumulates final product -> OUT; OUT holds until out_valid&&out_ready, then -> MAC for next pixel or -> DONE after pixel (O-1,O-1); DONE pulses done -> IDLE.
- Tap image coordinate = (orow*S + kr - P, ocol*S + kc - P). Out-of-bounds taps: img_rd low, product forced to 0; k_addr still issued.
- Products DW×DW → 2·DW bits, sign- or zero-extended per SIGNED to ACC_W; accumulation wraps modulo 2^ACC_W, no saturation. Accumulator cleared at the first tap of each pixel.
- start while busy is ignored. rst at any time returns to IDLE within the same edge; job discarded.
- Reset values: img_rd 0, img_addr 0, k_addr 0, out_valid 0, out_data 0, out_row 0, out_col 0, busy 0, done 0, cfg_err 0.

## Timing
- Start cycle = cycle 0. Taps issued cycles 1..K*K; tap t data used cycle t+1; DRAIN cycle K*K+1; out_valid high from cycle K*K+2.
- out_valid, out_data, out_row, out_col stable while out_ready low; no addresses issued in OUT.
- After handshake in cycle c, next pixel first tap issued cycle c+1; per-pixel period K*K+2 cycles with out_ready held high.
- done asserts the cycle after the final handshake; busy high from cycle 1 to the done cycle inclusive.
- cfg_err asserts cycle 1; busy stays low.

## Structure
- Package conv_pkg: FSM state enum (IDLE, MAC, DRAIN, OUT, DONE), config record type, output-size function.
- Sub-module conv_mac: registered multiply, sign/zero extension, zero-forcing and clear/accumulate; top holds FSM, tap/pixel counters and address generation.

## Test plan
- N=10, K=3, S=4, P=0, all-ones image/kernel -> 4 results of 9 at (0,0),(0,1),(1,0),(1,1); done one cycle after 4th handshake.
- N=4 image 0..15 ramp, K=2 all-ones, S=2 -> results 10, 18, 42, 50 in raster order.
- N=3 ones, K=3 ones, S=1, P=1 -> 9 results: corners 4, edges 6, centre 9; img_rd never asserted for out-of-bounds taps.
- Hold out_ready low 5 cycles on first result -> out_valid/out_data/tags stable, img_rd/addresses idle, resumes next cycle after ready.
- SIGNED=1, N=1, K=1, img 8'hFF, kernel 8'h02 -> out_data 20'hFFFFE.
- start with S=0 -> cfg_err pulse cycle 1, no out_valid; then valid job with rst mid-MAC -> all outputs at reset values next cycle, no done.
